mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the EXE stage; owns the HI/LO registers.
- Supplies the 32-bit MUL product that the EXE ALU selects for its MUL op.
- Accepts MULT/MULTU/MUL/DIV/DIVU/MTHI/MTLO from EXE and stalls the pipeline while busy.
- Aborts cleanly on pipeline flush (exception).

Parameters:
- MUL_CYCLES, 2, number of BUSY cycles for MULT/MULTU/MUL (range 1..8); the product is registered at issue and released after this count.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- EXE_MDUOp  in  4  0000 NOP, 0001 MULT, 0010 MULTU, 0011 MUL, 0100 DIV, 0101 DIVU, 0110 MTHI, 0111 MTLO; all other codes are NOP
- EXE_ResultA  in  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
- EXE_ResultB  in  32  rt operand (divisor / multiplier)
- EXE_Valid  in  1  EXE holds a live instruction
- Flush  in  1  kill EXE instruction and abort any operation in flight
- MDU_Busy  out  1  stall request to the pipeline (combinational)
- MDU_Done  out  1  one-cycle pulse in the DONE state
- MUL_Out  out  32  low word of the last MUL result (registered)
- HI_Out  out  32  HI register
- LO_Out  out  32  LO register

Behaviour:
- Reset: state=IDLE, HI=LO=MUL_Out=0, counter=0, MDU_Done=0. MDU_Busy=0 while rst=1. Reset mid-operation discards the operation; HI/LO still go to 0.
- States: IDLE, BUSY, DONE.
- Multi-cycle ops: MULT, MULTU, MUL, DIV, DIVU. Single-cycle ops: MTHI, MTLO.
- MDU_Busy is 1 in:
  - IDLE when EXE_Valid & multi-cycle op & ~Flush;
  - BUSY when ~Flush.
  - It is 0 otherwise, including in DONE.
- IDLE:
  - EXE_Valid & ~Flush & multi-cycle op: capture op and operands, go to BUSY. Counter loads MUL_CYCLES-1 (mul) or 31 (div).
  - For a mul op, the 64-bit product (signed for MULT/MUL, unsigned for MULTU) is registered on the same edge.
  - MTHI/MTLO with EXE_Valid & ~Flush: write HI/LO from EXE_ResultA at the edge; no stall; state stays IDLE.
- BUSY:
  - Counter decrements each cycle.
  - Divider: restoring radix-2, one quotient bit per cycle, on absolute values; signs are applied at completion.
  - When counter==0 and ~Flush, the edge writes the result and moves to DONE:
    - MULT/MULTU: HI=prod[63:32], LO=prod[31:0].
    - MUL: MUL_Out=prod[31:0]; HI/LO unchanged.
    - DIV/DIVU: LO=quotient, HI=remainder.
  - Flush=1 in any BUSY cycle: next state IDLE; no HI/LO/MUL_Out write; MDU_Done stays 0.
- DONE: MDU_Done=1 and MDU_Busy=0, so the pipeline advances the finished instruction at this edge. Unconditional transition to IDLE; no new op is accepted in DONE.
- Latency, with the issue cycle t0 (MDU_Busy=1):
  - mul: BUSY t1..tMUL_CYCLES, DONE at tMUL_CYCLES+1, total stall 1+MUL_CYCLES cycles.
  - div: BUSY t1..t32, DONE at t33, total stall 33 cycles.
- Operands are sampled only at issue; EXE input changes during BUSY are ignored.
- Division rules:
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
  - Divisor 0 (both DIV and DIVU): LO=0xFFFFFFFF, HI=dividend. No trap.
- HI_Out/LO_Out always reflect the register contents; the MFHI/MFLO forwarding of a same-cycle write is the pipeline's job.
- Flush in IDLE blocks both issue and MTHI/MTLO writes.

Test Plan:
- MULT A=0xFFFFFFFF B=0x00000002, MUL_CYCLES=2 -> MDU_Busy high t0..t2, MDU_Done at t3, HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE; MUL A=0x00010000 B=0x00010000 -> MUL_Out=0x00000000, HI/LO unchanged.
- DIV A=0xFFFFFFF9 (-7) B=2 -> Busy for 33 cycles, DONE at t33, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7 B=0 -> LO=0xFFFFFFFF, HI=7.
- DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0; then MTHI A=0x12345678 -> HI=0x12345678 next cycle, no Busy.
- DIVU 100/3 with Flush at t10 -> Busy=0 at t10, IDLE at t11, HI/LO keep their prior values, no MDU_Done; a MULT issued at t11 completes normally.
- rst asserted at t5 of a DIV -> next cycle IDLE, HI=LO=MUL_Out=0, MDU_Busy=0.

Source files
------------

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
//
// Multi-cycle multiply/divide sequencer for the EXE stage. Owns the HI/LO
// registers and supplies the low 32 bits of the last MUL product.
//
// Operation:
//   - MULT/MULTU/MUL/DIV/DIVU are multi-cycle. The pipeline is stalled while
//     one of them is in flight.
//   - MTHI/MTLO write HI/LO in one cycle and do not stall.
//   - Flush aborts an operation in flight without touching any result register.
//
// Multiply:
//   The 64-bit product is registered at issue. It is released after
//   MUL_CYCLES busy cycles.
//
// Divide:
//   Restoring radix-2 division on absolute values, one quotient bit per cycle.
//   Signs are applied when the result is written.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   EXE_MDUOp    operation code from EXE:
//                  0 NOP, 1 MULT, 2 MULTU, 3 MUL, 4 DIV, 5 DIVU, 6 MTHI, 7 MTLO
//                  any other code is a NOP
//   EXE_ResultA  rs operand (dividend / multiplicand / MTHI-MTLO source)
//   EXE_ResultB  rt operand (divisor / multiplier)
//   EXE_Valid    EXE holds a live instruction
//   Flush        kill the EXE instruction and abort any operation in flight
//   MDU_Busy     stall request to the pipeline (combinational)
//   MDU_Done     one-cycle pulse while in DONE
//   MUL_Out      low word of the last MUL result
//   HI_Out       HI register
//   LO_Out       LO register
// -----------------------------------------------------------------------------
module mdu_ctrl #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  EXE_MDUOp,
    input  logic [31:0] EXE_ResultA,
    input  logic [31:0] EXE_ResultB,
    input  logic        EXE_Valid,
    input  logic        Flush,
    output logic        MDU_Busy,
    output logic        MDU_Done,
    output logic [31:0] MUL_Out,
    output logic [31:0] HI_Out,
    output logic [31:0] LO_Out
);

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_MUL   = 4'b0011;
    localparam logic [3:0] OP_DIV   = 4'b0100;
    localparam logic [3:0] OP_DIVU  = 4'b0101;
    localparam logic [3:0] OP_MTHI  = 4'b0110;
    localparam logic [3:0] OP_MTLO  = 4'b0111;

    localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DIV_LOAD = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Returns 1 for the three multiply opcodes.
    function automatic logic op_is_mul(input logic [3:0] op);
        logic r;
        case (op)
            OP_MULT, OP_MULTU, OP_MUL: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

    // Returns 1 for the two divide opcodes.
    function automatic logic op_is_div(input logic [3:0] op);
        logic r;
        case (op)
            OP_DIV, OP_DIVU: r = 1'b1;
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

    // Two's-complement magnitude of a 32-bit value when neg is set.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic neg);
        logic [31:0] r;
        if (neg) begin
            r = 32'd0 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_t      state_r;
    logic [3:0]  op_r;
    logic [4:0]  cnt_r;
    logic [63:0] prod_r;
    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic [31:0] dvsr_r;
    logic [31:0] dividend_r;
    logic        q_neg_r;
    logic        r_neg_r;
    logic        div_zero_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] mul_out_r;
    logic        done_r;

    // ---------------------------------------------------------------------
    // Combinational decode and datapath
    // ---------------------------------------------------------------------
    logic        multi_op_s;
    logic        issue_s;
    logic        mt_write_s;
    logic        mul_signed_s;
    logic        div_signed_s;
    logic [63:0] a_ext_s;
    logic [63:0] b_ext_s;
    logic [63:0] mul_prod_s;
    logic [32:0] shift_s;
    logic [32:0] trial_s;
    logic [31:0] rem_nxt_s;
    logic [31:0] quo_nxt_s;
    logic [31:0] q_fin_s;
    logic [31:0] r_fin_s;

    assign multi_op_s = op_is_mul(EXE_MDUOp) | op_is_div(EXE_MDUOp);
    assign issue_s    = (state_r == ST_IDLE) & EXE_Valid & ~Flush & multi_op_s;
    assign mt_write_s = (state_r == ST_IDLE) & EXE_Valid & ~Flush &
                        ((EXE_MDUOp == OP_MTHI) | (EXE_MDUOp == OP_MTLO));

    assign mul_signed_s = (EXE_MDUOp == OP_MULT) | (EXE_MDUOp == OP_MUL);
    assign div_signed_s = (EXE_MDUOp == OP_DIV);

    // Sign- or zero-extending both operands to 64 bits makes the low 64 bits
    // of an unsigned multiply equal to the signed product when needed.
    assign a_ext_s    = mul_signed_s ? {{32{EXE_ResultA[31]}}, EXE_ResultA}
                                     : {32'd0, EXE_ResultA};
    assign b_ext_s    = mul_signed_s ? {{32{EXE_ResultB[31]}}, EXE_ResultB}
                                     : {32'd0, EXE_ResultB};
    assign mul_prod_s = a_ext_s * b_ext_s;

    // One restoring-division step. The partial remainder never exceeds the
    // divisor, so 33 bits cover the shifted value.
    assign shift_s   = {rem_r, quo_r[31]};
    assign trial_s   = shift_s - {1'b0, dvsr_r};
    assign rem_nxt_s = trial_s[32] ? shift_s[31:0] : trial_s[31:0];
    assign quo_nxt_s = {quo_r[30:0], ~trial_s[32]};

    // Final signed fix-up of the last step.
    // The divide-by-zero result is forced rather than derived from the array.
    always_comb begin
        q_fin_s = 32'd0;
        r_fin_s = 32'd0;
        if (div_zero_r) begin
            q_fin_s = 32'hFFFF_FFFF;
            r_fin_s = dividend_r;
        end else begin
            q_fin_s = abs32(quo_nxt_s, q_neg_r);
            r_fin_s = abs32(rem_nxt_s, r_neg_r);
        end
    end

    // Stall request: asserted while an op is being accepted or is in flight.
    always_comb begin
        MDU_Busy = 1'b0;
        if (rst) begin
            MDU_Busy = 1'b0;
        end else if (issue_s) begin
            MDU_Busy = 1'b1;
        end else if ((state_r == ST_BUSY) && !Flush) begin
            MDU_Busy = 1'b1;
        end else begin
            MDU_Busy = 1'b0;
        end
    end

    // Sequencer FSM: issue, iterate, write results, HI/LO ownership.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            op_r       <= 4'd0;
            cnt_r      <= 5'd0;
            prod_r     <= 64'd0;
            rem_r      <= 32'd0;
            quo_r      <= 32'd0;
            dvsr_r     <= 32'd0;
            dividend_r <= 32'd0;
            q_neg_r    <= 1'b0;
            r_neg_r    <= 1'b0;
            div_zero_r <= 1'b0;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
            mul_out_r  <= 32'd0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (issue_s) begin
                        state_r <= ST_BUSY;
                        op_r    <= EXE_MDUOp;
                        if (op_is_mul(EXE_MDUOp)) begin
                            cnt_r  <= MUL_LOAD;
                            prod_r <= mul_prod_s;
                        end else begin
                            cnt_r      <= DIV_LOAD;
                            rem_r      <= 32'd0;
                            quo_r      <= abs32(EXE_ResultA, div_signed_s & EXE_ResultA[31]);
                            dvsr_r     <= abs32(EXE_ResultB, div_signed_s & EXE_ResultB[31]);
                            dividend_r <= EXE_ResultA;
                            q_neg_r    <= div_signed_s & (EXE_ResultA[31] ^ EXE_ResultB[31]);
                            r_neg_r    <= div_signed_s & EXE_ResultA[31];
                            div_zero_r <= (EXE_ResultB == 32'd0);
                        end
                    end else if (mt_write_s) begin
                        if (EXE_MDUOp == OP_MTHI) begin
                            hi_r <= EXE_ResultA;
                        end else begin
                            lo_r <= EXE_ResultA;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_BUSY: begin
                    if (Flush) begin
                        // Abort: nothing is written, no done pulse.
                        state_r <= ST_IDLE;
                        done_r  <= 1'b0;
                    end else if (cnt_r == 5'd0) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        case (op_r)
                            OP_MULT, OP_MULTU: begin
                                hi_r <= prod_r[63:32];
                                lo_r <= prod_r[31:0];
                            end
                            OP_MUL: begin
                                mul_out_r <= prod_r[31:0];
                            end
                            OP_DIV, OP_DIVU: begin
                                hi_r <= r_fin_s;
                                lo_r <= q_fin_s;
                            end
                            default: begin
                                hi_r <= hi_r;
                            end
                        endcase
                    end else begin
                        cnt_r  <= cnt_r - 5'd1;
                        done_r <= 1'b0;
                        if (op_is_div(op_r)) begin
                            rem_r <= rem_nxt_s;
                            quo_r <= quo_nxt_s;
                        end else begin
                            rem_r <= rem_r;
                        end
                    end
                end

                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end

                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign MDU_Done = done_r;
    assign MUL_Out  = mul_out_r;
    assign HI_Out   = hi_r;
    assign LO_Out   = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl
//
// Scoreboard bench for mdu_ctrl.
//
// The driver computes each multi-cycle result with plain arithmetic and queues
// the expected HI/LO/MUL_Out together with the expected latency. A separate
// monitor pops the queue on every MDU_Done pulse and compares.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;

    localparam int MC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  EXE_MDUOp;
    logic [31:0] EXE_ResultA;
    logic [31:0] EXE_ResultB;
    logic        EXE_Valid;
    logic        Flush;
    logic        MDU_Busy;
    logic        MDU_Done;
    logic [31:0] MUL_Out;
    logic [31:0] HI_Out;
    logic [31:0] LO_Out;

    mdu_ctrl #(.MUL_CYCLES(MC)) dut (
        .clk(clk), .rst(rst), .EXE_MDUOp(EXE_MDUOp),
        .EXE_ResultA(EXE_ResultA), .EXE_ResultB(EXE_ResultB),
        .EXE_Valid(EXE_Valid), .Flush(Flush), .MDU_Busy(MDU_Busy),
        .MDU_Done(MDU_Done), .MUL_Out(MUL_Out), .HI_Out(HI_Out), .LO_Out(LO_Out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] mo;
        int          t0;
        int          n;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] hi_m, lo_m, mo_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference division from the architectural rules.
    task automatic div_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        int ia, ib;
        ia = a;
        ib = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = ia / ib;
            r = ia % ib;
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Monitor: counts stall cycles and checks every completion.
    int busy_cnt = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst || Flush) begin
                busy_cnt = 0;
            end else if (MDU_Busy) begin
                busy_cnt++;
            end
            if (MDU_Done) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done actual=1 required=0 (t=%0t)", $time);
                end else begin
                    e = sbq.pop_front();
                    chk("done_hi", HI_Out, e.hi);
                    chk("done_lo", LO_Out, e.lo);
                    chk("done_mul_out", MUL_Out, e.mo);
                    chk("done_latency", 32'(cyc - e.t0), 32'(e.n));
                    chk("stall_cycles", 32'(busy_cnt), 32'(e.n));
                    chk("busy_in_done", 32'(MDU_Busy), 32'd0);
                end
                busy_cnt = 0;
            end
        end
    end

    // Issue one op at the current cycle (called #1 after a posedge) and
    // return #1 after the posedge following completion.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        logic [31:0] q, r;
        longint      sa, sb;
        int          ia, ib;
        bit          multi;
        bit          seen;
        int          n;
        multi = (op >= 4'd1) && (op <= 4'd5);
        n = 0;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        EXE_MDUOp   = op;
        EXE_ResultA = a;
        EXE_ResultB = b;
        EXE_Valid   = 1'b1;
        case (op)
            4'd1: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; n = MC + 1; end
            4'd2: begin p = {32'd0, a} * {32'd0, b}; hi_m = p[63:32]; lo_m = p[31:0]; n = MC + 1; end
            4'd3: begin p = sa * sb; mo_m = p[31:0]; n = MC + 1; end
            4'd4: begin div_ref(1'b1, a, b, q, r); lo_m = q; hi_m = r; n = 33; end
            4'd5: begin div_ref(1'b0, a, b, q, r); lo_m = q; hi_m = r; n = 33; end
            4'd6: hi_m = a;
            4'd7: lo_m = a;
            default: n = 0;
        endcase
        if (multi) begin
            e.hi = hi_m;
            e.lo = lo_m;
            e.mo = mo_m;
            e.t0 = cyc;
            e.n  = n;
            sbq.push_back(e);
        end
        @(negedge clk);
        chk("busy_at_issue", 32'(MDU_Busy), 32'(multi));
        @(posedge clk);
        #1;
        EXE_Valid   = 1'b0;
        EXE_MDUOp   = 4'($urandom);
        EXE_ResultA = $urandom;
        EXE_ResultB = $urandom;
        if (multi) begin
            seen = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (MDU_Done) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) begin
                total++;
                bad++;
                $display("FAIL done_timeout actual=0 required=1 op=%0d", op);
            end
            @(posedge clk);
            #1;
        end else begin
            chk("single_hi", HI_Out, hi_m);
            chk("single_lo", LO_Out, lo_m);
            chk("single_mul_out", MUL_Out, mo_m);
            chk("single_busy", 32'(MDU_Busy), 32'd0);
        end
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        Flush       = 1'b0;
        EXE_Valid   = 1'b1;
        EXE_MDUOp   = 4'd1;
        EXE_ResultA = 32'd5;
        EXE_ResultB = 32'd6;
        hi_m = 32'd0;
        lo_m = 32'd0;
        mo_m = 32'd0;

        // Reset: outputs cleared, no stall even with a live MULT presented.
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_busy", 32'(MDU_Busy), 32'd0);
        chk("reset_done", 32'(MDU_Done), 32'd0);
        chk("reset_hi", HI_Out, 32'd0);
        chk("reset_lo", LO_Out, 32'd0);
        chk("reset_mul_out", MUL_Out, 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        EXE_Valid = 1'b0;

        // Directed cases from the test plan.
        run_op(4'd1, 32'hFFFF_FFFF, 32'h0000_0002);
        run_op(4'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        run_op(4'd3, 32'h0001_0000, 32'h0001_0000);
        run_op(4'd4, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op(4'd5, 32'h0000_0007, 32'h0000_0000);
        run_op(4'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(4'd6, 32'h1234_5678, 32'h0000_0000);
        run_op(4'd3, 32'hFFFF_FFFD, 32'h0000_0007);

        // Flush at t10 of a DIVU: abort, no writes, then MULT at t11.
        EXE_MDUOp   = 4'd5;
        EXE_ResultA = 32'd100;
        EXE_ResultB = 32'd3;
        EXE_Valid   = 1'b1;
        @(posedge clk);
        #1;
        EXE_Valid = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        Flush = 1'b1;
        @(negedge clk);
        chk("flush_busy", 32'(MDU_Busy), 32'd0);
        @(posedge clk);
        #1;
        Flush = 1'b0;
        chk("flush_hi_kept", HI_Out, hi_m);
        chk("flush_lo_kept", LO_Out, lo_m);
        run_op(4'd1, 32'h0000_1234, 32'hFFFF_0000);

        // Flush in IDLE blocks MTLO and MULT issue.
        EXE_MDUOp   = 4'd7;
        EXE_ResultA = 32'hDEAD_BEEF;
        EXE_Valid   = 1'b1;
        Flush       = 1'b1;
        @(negedge clk);
        chk("idle_flush_busy_mt", 32'(MDU_Busy), 32'd0);
        @(posedge clk);
        #1;
        EXE_MDUOp = 4'd1;
        @(negedge clk);
        chk("idle_flush_busy_mult", 32'(MDU_Busy), 32'd0);
        @(posedge clk);
        #1;
        Flush     = 1'b0;
        EXE_Valid = 1'b0;
        chk("idle_flush_lo_kept", LO_Out, lo_m);
        @(negedge clk);
        chk("idle_flush_not_busy", 32'(MDU_Busy), 32'd0);
        @(posedge clk);
        #1;

        // Random traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom_range(0, 9)), rnd_val(), rnd_val());
        end

        // Reset at t5 of a DIV discards it and clears HI/LO/MUL_Out.
        run_op(4'd3, 32'h0000_0003, 32'h0000_0005);
        EXE_MDUOp   = 4'd4;
        EXE_ResultA = 32'hFFFF_FF00;
        EXE_ResultB = 32'd7;
        EXE_Valid   = 1'b1;
        @(posedge clk);
        #1;
        EXE_Valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 32'(MDU_Busy), 32'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        hi_m = 32'd0;
        lo_m = 32'd0;
        mo_m = 32'd0;
        @(negedge clk);
        chk("rst_mid_hi", HI_Out, 32'd0);
        chk("rst_mid_lo", LO_Out, 32'd0);
        chk("rst_mid_mul_out", MUL_Out, 32'd0);
        chk("rst_mid_idle", 32'(MDU_Busy), 32'd0);
        @(posedge clk);
        #1;
        run_op(4'd4, 32'h0000_0064, 32'hFFFF_FFFD);

        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
